// File: rtl/mac_burst_if.sv
// Handshake bundle between the multiply-add stage, the burst accumulator and
// the result consumer.
//   in_data/in_valid/in_ready/flush : input word stream and burst close request
//   out_data/out_sat/out_partial    : head result entry
//   out_valid/out_ready             : result stream handshake
interface mac_burst_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 24
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [ACC_W-1:0] out_data;
    logic             out_sat;
    logic             out_partial;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sat, out_partial, out_valid
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_sat, out_partial, out_valid
    );
endinterface

// File: rtl/mac_burst_accumulator.sv
// Sums BURST consecutive multiply-add results into a saturating accumulator and
// queues each finished sum (with saturated/partial flags) in a small show-ahead
// FIFO with a registered head.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : input word stream, flush, result stream (see mac_burst_if)
//   burst_cnt    : words accumulated in the current burst
//   overflow_err : sticky, set when a word is offered while in_ready is low
module mac_burst_accumulator #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = IN_W + 8,
    parameter int unsigned BURST = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mac_burst_if.slave               bus,
    output logic [$clog2(BURST)-1:0] burst_cnt,
    output logic                     overflow_err
);
    localparam int unsigned CW = $clog2(BURST);
    localparam int unsigned NW = CW + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = PW + 1;
    localparam int unsigned SW = ACC_W + 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(BURST - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] mem_data_q [DEPTH];
    logic             mem_sat_q  [DEPTH];
    logic             mem_part_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    count_q, count_d;

    logic [ACC_W-1:0] head_data_q, head_data_d;
    logic             head_sat_q, head_sat_d;
    logic             head_part_q, head_part_d;
    logic             head_vld_q, head_vld_d;

    logic             fifo_full_c, in_ready_c, accept_c, close_c;
    logic             do_flush_c, push_c, pop_c, push_part_c, sat_new_c;
    logic [SW-1:0]    sum_c;
    logic [ACC_W-1:0] acc_new_c;
    logic [NW-1:0]    words_c;

    // Accumulate / close / flush decisions and FIFO bookkeeping
    always_comb begin
        acc_d       = acc_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        head_data_d = head_data_q;
        head_sat_d  = head_sat_q;
        head_part_d = head_part_q;

        fifo_full_c = (count_q == FW'(DEPTH));
        // Stall only when this cycle would need a free FIFO slot
        in_ready_c  = !(fifo_full_c && ((cnt_q == LAST_CNT) || bus.flush));
        accept_c    = bus.in_valid && in_ready_c;
        ovf_d       = ovf_q || (bus.in_valid && !in_ready_c);

        sum_c       = SW'(acc_q) + SW'(bus.in_data);
        acc_new_c   = sum_c[ACC_W] ? ACC_MAX : sum_c[ACC_W-1:0];
        sat_new_c   = sat_q || sum_c[ACC_W];
        words_c     = NW'(cnt_q) + NW'(accept_c);

        close_c     = accept_c && (cnt_q == LAST_CNT);
        do_flush_c  = bus.flush && in_ready_c;
        push_c      = close_c || (do_flush_c && (words_c != '0));
        // A flush that lands on the closing word is a full burst
        push_part_c = !close_c;
        pop_c       = head_vld_q && bus.out_ready;

        if (push_c || do_flush_c) begin
            acc_d = '0;
            sat_d = 1'b0;
            cnt_d = '0;
        end else if (accept_c) begin
            acc_d = acc_new_c;
            sat_d = sat_new_c;
            cnt_d = cnt_q + CW'(1);
        end

        if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d    = count_q + FW'(push_c) - FW'(pop_c);
        head_vld_d = (count_d != '0);

        // Head register follows the entry at the new read pointer; that entry
        // is the one being pushed when the FIFO was (or becomes) empty.
        if (head_vld_d) begin
            if (push_c && (rd_ptr_d == wr_ptr_q)) begin
                head_data_d = acc_eff();
                head_sat_d  = accept_c ? sat_new_c : sat_q;
                head_part_d = push_part_c;
            end else begin
                head_data_d = mem_data_q[rd_ptr_d];
                head_sat_d  = mem_sat_q[rd_ptr_d];
                head_part_d = mem_part_q[rd_ptr_d];
            end
        end
    end

    // Sum including the current word when it is accepted
    function automatic logic [ACC_W-1:0] acc_eff();
        return accept_c ? acc_new_c : acc_q;
    endfunction

    // State and FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_data_q <= '0;
            head_sat_q  <= 1'b0;
            head_part_q <= 1'b0;
            head_vld_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data_q[i] <= '0;
                mem_sat_q[i]  <= 1'b0;
                mem_part_q[i] <= 1'b0;
            end
        end else begin
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_sat_q  <= head_sat_d;
            head_part_q <= head_part_d;
            head_vld_q  <= head_vld_d;
            if (push_c) begin
                mem_data_q[wr_ptr_q] <= acc_eff();
                mem_sat_q[wr_ptr_q]  <= accept_c ? sat_new_c : sat_q;
                mem_part_q[wr_ptr_q] <= push_part_c;
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_data    = head_data_q;
    assign bus.out_sat     = head_sat_q;
    assign bus.out_partial = head_part_q;
    assign bus.out_valid   = head_vld_q;
    assign burst_cnt       = cnt_q;
    assign overflow_err    = ovf_q;
endmodule

// File: tb/tb_mac_burst_accumulator.sv
// Directed bench for mac_burst_accumulator: a per-cycle vector table for the
// streaming cases plus hand-written sequences for backpressure, saturation and
// asynchronous reset.
module tb_mac_burst_accumulator;
    localparam int unsigned IN_W   = 16;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned ACC_W2 = 17;
    localparam int unsigned BURST  = 4;
    localparam int unsigned DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mac_burst_if #(.IN_W(IN_W), .ACC_W(ACC_W))  bus ();
    mac_burst_if #(.IN_W(IN_W), .ACC_W(ACC_W2)) bus2 ();
    logic [1:0] burst_cnt, burst_cnt2;
    logic       ovf, ovf2;

    mac_burst_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .BURST(BURST), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .burst_cnt(burst_cnt), .overflow_err(ovf));

    mac_burst_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W2), .BURST(BURST), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .burst_cnt(burst_cnt2), .overflow_err(ovf2));

    typedef struct {
        int unsigned vld, d, fl, ordy;
        int unsigned e_rdy, e_vld, e_data, e_sat, e_part, e_cnt;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input int unsigned vld, d, fl, ordy,
                                input int unsigned e_rdy, e_vld, e_data, e_sat, e_part, e_cnt);
        vec_t v;
        v.vld = vld; v.d = d; v.fl = fl; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data;
        v.e_sat = e_sat; v.e_part = e_part; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endfunction

    task automatic drive(input int unsigned vld, d, fl, ordy);
        bus.in_valid  = 1'(vld);
        bus.in_data   = 16'(d);
        bus.flush     = 1'(fl);
        bus.out_ready = 1'(ordy);
    endtask

    task automatic drive2(input int unsigned vld, d);
        bus2.in_valid  = 1'(vld);
        bus2.in_data   = 16'(d);
        bus2.flush     = 1'b0;
        bus2.out_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int unsigned exp6 [4] = '{6, 22, 38, 54};

    initial begin
        int unsigned last;
        drive(0, 0, 0, 0);
        drive2(0, 0);

        // Test 1: 1+2+3+4, then pop leaves out_data holding 10
        add(1, 1, 0, 1,  1, 0, 0,  0, 0, 1);
        add(1, 2, 0, 1,  1, 0, 0,  0, 0, 2);
        add(1, 3, 0, 1,  1, 0, 0,  0, 0, 3);
        add(1, 4, 0, 1,  1, 1, 10, 0, 0, 0);
        add(0, 0, 0, 1,  1, 0, 10, 0, 0, 0);
        // Test 2: 3 x 5 then flush alone; flush at count 0 is a no-op
        add(1, 5, 0, 0,  1, 0, 10, 0, 0, 1);
        add(1, 5, 0, 0,  1, 0, 10, 0, 0, 2);
        add(1, 5, 0, 0,  1, 0, 10, 0, 0, 3);
        add(0, 0, 1, 0,  1, 1, 15, 0, 1, 0);
        add(0, 0, 1, 1,  1, 0, 15, 0, 1, 0);
        // Flush together with the first word of a burst
        add(1, 7, 1, 0,  1, 1, 7,  0, 1, 0);
        add(0, 0, 0, 1,  1, 0, 7,  0, 1, 0);
        // Flush together with the closing word: full burst, partial=0
        add(1, 1, 0, 0,  1, 0, 7,  0, 1, 1);
        add(1, 1, 0, 0,  1, 0, 7,  0, 1, 2);
        add(1, 1, 0, 0,  1, 0, 7,  0, 1, 3);
        add(1, 1, 1, 0,  1, 1, 4,  0, 0, 0);
        add(0, 0, 0, 1,  1, 0, 4,  0, 0, 0);
        // Test 6: continuous stream k=0..15 with out_ready=1
        last = 4;
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 3) last = exp6[k / 4];
            add(1, k, 0, 1,  1, (k % 4 == 3) ? 1 : 0, last, 0, 0, (k + 1) % 4);
        end
        add(0, 0, 0, 1,  1, 0, 54, 0, 0, 0);

        // Reset
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("rst out_valid",   32'(bus.out_valid), 0);
        chk("rst out_data",    32'(bus.out_data), 0);
        chk("rst out_sat",     32'(bus.out_sat), 0);
        chk("rst out_partial", 32'(bus.out_partial), 0);
        chk("rst burst_cnt",   32'(burst_cnt), 0);
        chk("rst overflow",    32'(ovf), 0);
        chk("rst in_ready",    32'(bus.in_ready), 1);

        // Table-driven streaming vectors
        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].d, vecs[i].fl, vecs[i].ordy);
            #4;
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), vecs[i].e_rdy);
            tick();
            chk($sformatf("v%0d out_valid", i),   32'(bus.out_valid), vecs[i].e_vld);
            chk($sformatf("v%0d out_data", i),    32'(bus.out_data), vecs[i].e_data);
            chk($sformatf("v%0d out_sat", i),     32'(bus.out_sat), vecs[i].e_sat);
            chk($sformatf("v%0d out_partial", i), 32'(bus.out_partial), vecs[i].e_part);
            chk($sformatf("v%0d burst_cnt", i),   32'(burst_cnt), vecs[i].e_cnt);
        end

        // Test 3: fill FIFO, backpressure on the 5th burst close
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        chk("t3 full out_valid", 32'(bus.out_valid), 1);
        chk("t3 full out_data",  32'(bus.out_data), 4);
        chk("t3 full cnt",       32'(burst_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0);
            #4;
            chk("t3 in_ready early", 32'(bus.in_ready), 1);
            tick();
        end
        chk("t3 cnt3", 32'(burst_cnt), 3);
        drive(1, 1, 0, 0);
        #4;
        chk("t3 in_ready stall", 32'(bus.in_ready), 0);
        tick();
        chk("t3 overflow_err", 32'(ovf), 1);
        chk("t3 cnt held", 32'(burst_cnt), 3);
        drive(1, 1, 0, 1);
        #4;
        chk("t3 in_ready pop", 32'(bus.in_ready), 0);
        tick();
        drive(1, 1, 0, 0);
        #4;
        chk("t3 in_ready freed", 32'(bus.in_ready), 1);
        tick();
        chk("t3 cnt closed", 32'(burst_cnt), 0);
        chk("t3 overflow sticky", 32'(ovf), 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1);
            #4;
            chk($sformatf("t3 drain%0d valid", i), 32'(bus.out_valid), 1);
            chk($sformatf("t3 drain%0d data", i),  32'(bus.out_data), 4);
            tick();
        end
        chk("t3 drained", 32'(bus.out_valid), 0);
        drive(0, 0, 0, 0);

        // Test 4: saturation on the ACC_W=17 instance
        for (int i = 0; i < 4; i++) begin
            drive2(1, 16'hFFFF);
            tick();
        end
        chk("t4 sat valid", 32'(bus2.out_valid), 1);
        chk("t4 sat data",  32'(bus2.out_data), 32'h1FFFF);
        chk("t4 sat flag",  32'(bus2.out_sat), 1);
        chk("t4 sat part",  32'(bus2.out_partial), 0);
        for (int i = 0; i < 4; i++) begin
            drive2(1, 1);
            tick();
        end
        chk("t4 clean valid", 32'(bus2.out_valid), 1);
        chk("t4 clean data",  32'(bus2.out_data), 4);
        chk("t4 clean sat",   32'(bus2.out_sat), 0);
        drive2(0, 0);

        // Test 5: asynchronous reset mid-burst with 2 entries queued
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        chk("t5 pre valid", 32'(bus.out_valid), 1);
        chk("t5 pre cnt",   32'(burst_cnt), 2);
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 rst valid", 32'(bus.out_valid), 0);
        chk("t5 rst data",  32'(bus.out_data), 0);
        chk("t5 rst cnt",   32'(burst_cnt), 0);
        chk("t5 rst ovf",   32'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        chk("t5 post valid", 32'(bus.out_valid), 1);
        chk("t5 post data",  32'(bus.out_data), 4);
        drive(0, 0, 0, 1);
        tick();
        chk("t5 single entry", 32'(bus.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
